// File: rtl/dot_matrix_pkg.sv
// Shared types and helpers for the 8x8 dot-matrix scan capture block.
package dot_matrix_pkg;
  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef logic [COLS-1:0]      row_word_t;
  typedef logic [ROWS*COLS-1:0] frame_t;

  typedef enum logic {
    HUNT,
    COLLECT
  } scan_state_t;

  function automatic row_word_t row_slice(input frame_t f, input int r);
    return f[r*COLS +: COLS];
  endfunction
endpackage

// File: rtl/dot_matrix_row_merge.sv
// OR-merges one scan sample into the row buffer; dot_row is active-low, bit 7 = row 0.
module dot_matrix_row_merge
  import dot_matrix_pkg::*;
(
  input  frame_t    row_buf,
  input  row_word_t dot_row,
  input  row_word_t dot_col,
  output frame_t    row_buf_next
);

  always_comb begin
    row_buf_next = row_buf;
    for (int r = 0; r < ROWS; r++) begin
      if (!dot_row[ROWS-1-r]) begin
        row_buf_next[r*COLS +: COLS] = row_slice(row_buf, r) | dot_col;
      end
    end
  end

endmodule

// File: rtl/dot_matrix_scan_capture.sv
// Rebuilds 8x8 frames from a row-scanned dot-matrix interface and tracks scan lock.
//   state   | meaning
//   HUNT    | waiting for a start-of-frame sample (dot_row[7] low)
//   COLLECT | accumulating slots 0..7 of the current frame
module dot_matrix_scan_capture
  import dot_matrix_pkg::*;
#(
  parameter int SLOTS           = 8,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sample_en,
  input  logic [7:0]  dot_row,
  input  logic [7:0]  dot_col,
  output logic [63:0] frame,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic        sync_err,
  output logic        locked
);

  localparam int        CW        = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [2:0] LAST_SLOT = 3'(SLOTS - 1);

  scan_state_t   state_q, state_d;
  logic [2:0]    slot_q, slot_d;
  frame_t        buf_q, buf_d;
  frame_t        frame_q, frame_d;
  logic [CW-1:0] clean_q, clean_d;
  logic          fv_q, fv_d;
  logic          fc_q, fc_d;
  logic          se_q, se_d;

  logic   sof;
  frame_t merge_base;
  frame_t merged;

  // An SOF always starts a fresh buffer, whichever slot it lands on.
  assign sof        = ~dot_row[ROWS-1];
  assign merge_base = sof ? '0 : buf_q;

  dot_matrix_row_merge u_row_merge (
    .row_buf      (merge_base),
    .dot_row      (dot_row),
    .dot_col      (dot_col),
    .row_buf_next (merged)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= HUNT;
      slot_q  <= '0;
      buf_q   <= '0;
      frame_q <= '0;
      clean_q <= '0;
      fv_q    <= 1'b0;
      fc_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      buf_q   <= buf_d;
      frame_q <= frame_d;
      clean_q <= clean_d;
      fv_q    <= fv_d;
      fc_q    <= fc_d;
      se_q    <= se_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    buf_d   = buf_q;
    frame_d = frame_q;
    clean_d = clean_q;
    fv_d    = 1'b0;
    fc_d    = 1'b0;
    se_d    = 1'b0;
    if (sample_en) begin
      case (state_q)
        HUNT: begin
          if (sof) begin
            buf_d   = merged;
            slot_d  = 3'd1;
            state_d = COLLECT;
          end
        end
        COLLECT: begin
          if (slot_q == 3'd0 && !sof) begin
            se_d    = 1'b1;
            clean_d = '0;
            slot_d  = 3'd0;
            state_d = HUNT;
          end else if (sof) begin
            // SOF at slots 1..7 (including a frame-completing slot) is a resync.
            if (slot_q != 3'd0) begin
              se_d    = 1'b1;
              clean_d = '0;
            end
            buf_d  = merged;
            slot_d = 3'd1;
          end else if (slot_q == LAST_SLOT) begin
            buf_d   = merged;
            frame_d = merged;
            fv_d    = 1'b1;
            fc_d    = (merged != frame_q);
            slot_d  = 3'd0;
            if (clean_q != CW'(DEBOUNCE_FRAMES)) clean_d = clean_q + 1'b1;
          end else begin
            buf_d  = merged;
            slot_d = slot_q + 3'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    frame         = frame_q;
    frame_valid   = fv_q;
    frame_changed = fc_q;
    sync_err      = se_q;
    locked        = (clean_q == CW'(DEBOUNCE_FRAMES));
  end

endmodule

// File: tb/tb_dot_matrix_scan_capture.sv
// Directed vector bench for dot_matrix_scan_capture with hand-computed frames.
module tb_dot_matrix_scan_capture;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sample_en = 1'b0;
  logic [7:0]  dot_row = 8'hFF;
  logic [7:0]  dot_col = 8'h00;
  logic [63:0] frame;
  logic        frame_valid, frame_changed, sync_err, locked;

  dot_matrix_scan_capture dut (
    .clock         (clock),
    .reset         (reset),
    .sample_en     (sample_en),
    .dot_row       (dot_row),
    .dot_col       (dot_col),
    .frame         (frame),
    .frame_valid   (frame_valid),
    .frame_changed (frame_changed),
    .sync_err      (sync_err),
    .locked        (locked)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        en;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        fv;
    logic        fc;
    logic        se;
    logic        lk;
    logic        chk;
    logic [63:0] f;
  } vec_t;

  localparam logic [63:0] F_PAT   = 64'h7E42_4242_C342_2418;
  localparam logic [63:0] F_ROWFF = 64'h7E42_4242_C342_24FF;
  localparam logic [63:0] F_ROW00 = 64'h7E42_4242_C342_2400;
  localparam logic [63:0] F_R7    = 64'h0100_0000_0000_0000;

  vec_t       tbl[$];
  logic [7:0] pr[8];
  logic [7:0] pc[8];
  int         n_vec = 0;
  int         n_bad = 0;
  int         n_fv, n_se;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic en, input logic [7:0] r, input logic [7:0] c,
                      input logic fv, input logic fc, input logic se, input logic lk,
                      input logic ck = 1'b0, input logic [63:0] f = 64'h0);
    vec_t v;
    v.en = en; v.row = r; v.col = c; v.fv = fv; v.fc = fc; v.se = se; v.lk = lk;
    v.chk = ck; v.f = f;
    tbl.push_back(v);
  endtask

  // Reference pattern from slot `from` to slot 7; slot 7 publishes frame f.
  task automatic push_pat(input int from, input logic fc, input logic lk_mid,
                          input logic lk_end, input logic [63:0] f);
    for (int s = from; s < 8; s++) begin
      if (s == 7) push(1'b1, pr[s], pc[s], 1'b1, fc, 1'b0, lk_end, 1'b1, f);
      else        push(1'b1, pr[s], pc[s], 1'b0, 1'b0, 1'b0, lk_mid);
    end
  endtask

  task automatic send(input logic [7:0] r, input logic [7:0] c);
    @(negedge clock);
    sample_en = 1'b1;
    dot_row   = r;
    dot_col   = c;
    @(posedge clock);
    #1;
    sample_en = 1'b0;
  endtask

  task automatic idle(input logic [7:0] r, input logic [7:0] c);
    @(negedge clock);
    sample_en = 1'b0;
    dot_row   = r;
    dot_col   = c;
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset     = 1'b1;
    sample_en = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    pr[0] = 8'h7F; pr[1] = 8'hBF; pr[2] = 8'hDF; pr[3] = 8'hEF;
    pr[4] = 8'hF1; pr[5] = 8'hF1; pr[6] = 8'hF1; pr[7] = 8'hFE;
    pc[0] = 8'h18; pc[1] = 8'h24; pc[2] = 8'h42; pc[3] = 8'hC3;
    pc[4] = 8'h42; pc[5] = 8'h42; pc[6] = 8'h42; pc[7] = 8'h7E;

    // Four identical frames: changed only on the first, locked after the second.
    push_pat(0, 1'b1, 1'b0, 1'b0, F_PAT);
    push_pat(0, 1'b0, 1'b0, 1'b1, F_PAT);
    push_pat(0, 1'b0, 1'b1, 1'b1, F_PAT);
    push_pat(0, 1'b0, 1'b1, 1'b1, F_PAT);
    // Resync at slot 2 with 7F/FF; the restarted frame carries row 0 = FF.
    push(1'b1, 8'h7F, 8'h18, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b1, 8'hBF, 8'h24, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b1, 8'h7F, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, F_PAT);
    push_pat(1, 1'b1, 1'b0, 1'b0, F_ROWFF);
    // Same pattern with 5 idle cycles of noise between samples.
    for (int s = 0; s < 8; s++) begin
      if (s == 7) push(1'b1, pr[s], pc[s], 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, F_PAT);
      else begin
        push(1'b1, pr[s], pc[s], 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) push(1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, F_ROWFF);
      end
    end
    // SOF on the completing slot: no publish, resync, row 0 rebuilt as 00.
    for (int s = 0; s < 7; s++) push(1'b1, pr[s], pc[s], 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b1, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, F_PAT);
    push_pat(1, 1'b1, 1'b0, 1'b0, F_ROW00);
    // Non-SOF at slot 0 drops to HUNT; non-SOF in HUNT is silently ignored.
    push(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, F_ROW00);
    push(1'b1, 8'hBF, 8'h24, 1'b0, 1'b0, 1'b0, 1'b0);
    push_pat(0, 1'b1, 1'b0, 1'b0, F_PAT);

    pulse_reset();
    chk("rst.frame", frame, 64'h0);
    chk("rst.fv", frame_valid, 1'b0);
    chk("rst.fc", frame_changed, 1'b0);
    chk("rst.se", sync_err, 1'b0);
    chk("rst.lk", locked, 1'b0);

    foreach (tbl[i]) begin
      if (tbl[i].en) send(tbl[i].row, tbl[i].col);
      else           idle(tbl[i].row, tbl[i].col);
      chk($sformatf("v%0d.fv", i), frame_valid, tbl[i].fv);
      chk($sformatf("v%0d.fc", i), frame_changed, tbl[i].fc);
      chk($sformatf("v%0d.se", i), sync_err, tbl[i].se);
      chk($sformatf("v%0d.lk", i), locked, tbl[i].lk);
      if (tbl[i].chk) chk($sformatf("v%0d.frame", i), frame, tbl[i].f);
    end

    // Reset at slot 4 clears the published frame and discards the partial one.
    for (int s = 0; s < 4; s++) send(pr[s], pc[s]);
    pulse_reset();
    chk("midrst.frame", frame, 64'h0);
    chk("midrst.lk", locked, 1'b0);
    send(8'h7F, 8'h00);
    chk("r7.sof.frame", frame, 64'h0);
    for (int s = 1; s < 8; s++) begin
      send(8'hFE, 8'h01);
      if (s < 7) begin
        chk($sformatf("r7.s%0d.fv", s), frame_valid, 1'b0);
        chk($sformatf("r7.s%0d.frame", s), frame, 64'h0);
      end
    end
    chk("r7.fv", frame_valid, 1'b1);
    chk("r7.fc", frame_changed, 1'b1);
    chk("r7.frame", frame, F_R7);
    chk("r7.lk", locked, 1'b0);

    // Blank rows only: never leaves HUNT.
    pulse_reset();
    n_fv = 0;
    n_se = 0;
    repeat (20) begin
      send(8'hFF, 8'($urandom));
      n_fv += int'(frame_valid);
      n_se += int'(sync_err);
    end
    chk("blank.fv_count", 64'(n_fv), 64'd0);
    chk("blank.se_count", 64'(n_se), 64'd0);
    chk("blank.lk", locked, 1'b0);
    chk("blank.frame", frame, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
